cpu_trace_buffer: RTL and testbench

Parametrised retirement-trace unit for the single-cycle MIPS CPU. It watches the CPU's observable datapath/control signals each clock, records one entry per retired instruction (PC, kind, destination, data, cycle stamp) into a DEPTH-entry first-word-fall-through FIFO, and detects the halt opcode. It replaces ad-hoc waveform inspection in simulation and can be synthesised for on-board debug readout.

---
 rtl/cpu_trace_buffer_if.sv | 44 ++++
 rtl/cpu_trace_buffer.sv | 121 ++++++++++++
 tb/tb_cpu_trace_buffer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: CPU observation bus and trace read port
// master = CPU/reader side, slave = trace buffer side
interface cpu_trace_buffer_if #(
  parameter int CYC_W = 16,
  parameter int DEPTH = 16
);
  localparam int ENTRY_W = CYC_W + 71;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic [31:0]        pc_out;
  logic [31:0]        instr;
  logic               pc_wre;
  logic               reg_wre;
  logic [4:0]         write_reg;
  logic [31:0]        write_data;
  logic               m_wr;
  logic [31:0]        alu_result;
  logic               rd_en;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic [CW-1:0]      count;
  logic               overflow;
  logic [CYC_W-1:0]   drop_cnt;
  logic               halted;
  logic [CYC_W-1:0]   cycle;

  modport master (
    output pc_out, instr, pc_wre,
    output reg_wre, write_reg, write_data,
    output m_wr, alu_result, rd_en,
    input  rd_valid, rd_data, count,
    input  overflow, drop_cnt,
    input  halted, cycle
  );

  modport slave (
    input  pc_out, instr, pc_wre,
    input  reg_wre, write_reg, write_data,
    input  m_wr, alu_result, rd_en,
    output rd_valid, rd_data, count,
    output overflow, drop_cnt,
    output halted, cycle
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: retirement trace FIFO with halt detect
// TRACE_MEM_EN: log store retirements as kind 2'b10
module cpu_trace_buffer #(
  parameter int         CYC_W   = 16,
  parameter int         DEPTH   = 16,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input logic          clk,
  input logic          reset,
  cpu_trace_buffer_if.slave bus
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = CYC_W + 71;

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [CYC_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               halted_q, halted_d;
  logic [CYC_W-1:0]   cycle_q, cycle_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               ret;
  logic               is_halt;
  logic               full;
  logic               push;
  logic               pop;
  logic [1:0]         kind;
  logic [4:0]         dest;
  logic [31:0]        data;
  logic [ENTRY_W-1:0] entry;

`ifndef TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{bus.m_wr, bus.alu_result};
`endif

  // Classify the retiring instruction into a trace entry
  always_comb begin
    kind = 2'b00;
    dest = 5'd0;
    data = 32'd0;
    if (is_halt) begin
      kind = 2'b11;
      data = bus.instr;
    end else if (bus.reg_wre) begin
      kind = 2'b01;
      dest = bus.write_reg;
      data = bus.write_data;
    end
`ifdef TRACE_MEM_EN
    else if (bus.m_wr) begin
      kind = 2'b10;
      data = bus.alu_result;
    end
`endif
  end

  assign ret     = bus.pc_wre && !halted_q;
  assign is_halt = bus.instr[31:26] == HALT_OP;
  assign full    = count_q == CW'(DEPTH);
  assign pop     = bus.rd_en && (count_q != '0);
  assign push    = ret && (!full || pop);
  assign entry   = {cycle_q, bus.pc_out, kind, dest, data};

  // Next-state for pointers, occupancy, status and cycle counter
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    halted_d   = halted_q;
    cycle_d    = cycle_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (ret && !push) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1)
        drop_cnt_d = drop_cnt_q + CYC_W'(1);
    end
    if (ret && is_halt) halted_d = 1'b1;
    if (!halted_q) cycle_d = cycle_q + CYC_W'(1);
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      halted_q   <= 1'b0;
      cycle_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      halted_q   <= halted_d;
      cycle_q    <= cycle_d;
    end
  end

  // Entry storage, contents survive reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign bus.rd_valid = count_q != '0;
  assign bus.rd_data  = bus.rd_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.halted   = halted_q;
  assign bus.cycle    = cycle_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed checks of cpu_trace_buffer
// DEPTH=4 build, 16-bit cycle stamps
module tb_cpu_trace_buffer;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  cpu_trace_buffer_if #(.CYC_W(16), .DEPTH(4)) bus ();

  cpu_trace_buffer #(
    .CYC_W(16),
    .DEPTH(4),
    .HALT_OP(6'b111111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [86:0] ent(
    input logic [15:0] c, input logic [31:0] p,
    input logic [1:0] k, input logic [4:0] d,
    input logic [31:0] v);
    return {c, p, k, d, v};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rt(input logic [31:0] pc,
                    input logic re, input logic mw,
                    input logic [4:0] wr,
                    input logic [31:0] wd,
                    input logic [31:0] ins,
                    input logic rd);
    bus.pc_out     = pc;
    bus.pc_wre     = 1'b1;
    bus.reg_wre    = re;
    bus.m_wr       = mw;
    bus.write_reg  = wr;
    bus.write_data = wd;
    bus.alu_result = 32'h8;
    bus.instr      = ins;
    bus.rd_en      = rd;
    step();
    bus.pc_wre = 1'b0;
    bus.rd_en  = 1'b0;
  endtask

  task automatic pop_chk(input string tag,
                         input logic [15:0] c);
    chk(tag, 128'(bus.rd_data[86:71]), 128'(c));
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  logic [1:0]  st_kind;
  logic [31:0] st_data;

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.pc_out = '0; bus.instr = '0;
    bus.pc_wre = 0; bus.reg_wre = 0;
    bus.write_reg = '0; bus.write_data = '0;
    bus.m_wr = 0; bus.alu_result = '0;
    bus.rd_en = 0;
    reset = 1'b0;
    #3;
    chk("rst_count", 128'(bus.count), 128'd0);
    chk("rst_valid", 128'(bus.rd_valid), 128'd0);
    #3 reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      rt(32'(4 * i), 1, 0, 5'd5, 32'h1234, 32'h0, 0);
    chk("a_count", 128'(bus.count), 128'd3);
    chk("a_head", 128'(bus.rd_data),
        128'(ent(16'd0, 32'h0, 2'b01, 5'd5, 32'h1234)));

    for (int i = 3; i < 6; i++)
      rt(32'(4 * i), 1, 0, 5'd5, 32'h1234, 32'h0, 0);
    chk("b_count", 128'(bus.count), 128'd4);
    chk("b_ovf", 128'(bus.overflow), 128'd1);
    chk("b_drop", 128'(bus.drop_cnt), 128'd2);
    chk("b_headcyc", 128'(bus.rd_data[86:71]), 128'd0);
    chk("b_cycle", 128'(bus.cycle), 128'd6);

    rt(32'h18, 1, 0, 5'd5, 32'h1234, 32'h0, 1);
    chk("c_count", 128'(bus.count), 128'd4);
    chk("c_drop", 128'(bus.drop_cnt), 128'd2);

    pop_chk("p_cyc1", 16'd1);
    pop_chk("p_cyc2", 16'd2);
    pop_chk("p_cyc3", 16'd3);
    chk("p_tail", 128'(bus.rd_data),
        128'(ent(16'd6, 32'h18, 2'b01, 5'd5, 32'h1234)));
    pop_chk("p_cyc6", 16'd6);
    chk("e_valid", 128'(bus.rd_valid), 128'd0);
    chk("e_data", 128'(bus.rd_data), 128'd0);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("e_popempty", 128'(bus.count), 128'd0);
    chk("e_cycle", 128'(bus.cycle), 128'd12);

`ifdef TRACE_MEM_EN
    st_kind = 2'b10;
    st_data = 32'h8;
`else
    st_kind = 2'b00;
    st_data = 32'h0;
`endif
    rt(32'h1c, 0, 1, 5'd3, 32'h55, 32'h0, 0);
    chk("m_store", 128'(bus.rd_data),
        128'(ent(16'd12, 32'h1c, st_kind, 5'd0, st_data)));
    rt(32'h30, 1, 1, 5'd7, 32'hABCD, 32'h0, 1);
    chk("m_prio", 128'(bus.rd_data),
        128'(ent(16'd13, 32'h30, 2'b01, 5'd7, 32'hABCD)));
    rt(32'h34, 0, 0, 5'd7, 32'hABCD, 32'h0, 1);
    chk("m_plain", 128'(bus.rd_data),
        128'(ent(16'd14, 32'h34, 2'b00, 5'd0, 32'h0)));

    rt(32'h20, 1, 0, 5'd9, 32'h99, 32'hFC000000, 1);
    chk("h_entry", 128'(bus.rd_data),
        128'(ent(16'd15, 32'h20, 2'b11, 5'd0, 32'hFC000000)));
    chk("h_halted", 128'(bus.halted), 128'd1);
    chk("h_cycle", 128'(bus.cycle), 128'd16);
    rt(32'h24, 1, 0, 5'd5, 32'h1, 32'h0, 0);
    rt(32'h28, 1, 0, 5'd5, 32'h2, 32'h0, 0);
    chk("h_count", 128'(bus.count), 128'd1);
    chk("h_frozen", 128'(bus.cycle), 128'd16);
    chk("h_ovf_keep", 128'(bus.overflow), 128'd1);

    #2 reset = 1'b0;
    #1;
    chk("r_count", 128'(bus.count), 128'd0);
    chk("r_ovf", 128'(bus.overflow), 128'd0);
    chk("r_drop", 128'(bus.drop_cnt), 128'd0);
    chk("r_halt", 128'(bus.halted), 128'd0);
    chk("r_cycle", 128'(bus.cycle), 128'd0);
    chk("r_data", 128'(bus.rd_data), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    rt(32'h40, 1, 0, 5'd2, 32'h77, 32'h0, 0);
    chk("r2_entry", 128'(bus.rd_data),
        128'(ent(16'd0, 32'h40, 2'b01, 5'd2, 32'h77)));
    chk("r2_cycle", 128'(bus.cycle), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
